// File: rtl/decode_pkg.sv
// Shared constants for the RV32I decode stage.
//   - ALU_OP_WIDTH and INSTR_WIDTH widths
//   - opcode_e    : instruction[6:2] major opcodes
//   - alu_op_e    : ALU operation codes (base plus M extension)
//   - imm_sel_e   : immediate format select codes
//   - alu_from_funct3 / build_immediate helpers
package decode_pkg;

    localparam int unsigned ALU_OP_WIDTH = 5;
    localparam int unsigned INSTR_WIDTH  = 32;

    typedef enum logic [4:0] {
        OpcLoad   = 5'b00000,
        OpcOpImm  = 5'b00100,
        OpcAuipc  = 5'b00101,
        OpcStore  = 5'b01000,
        OpcOp     = 5'b01100,
        OpcLui    = 5'b01101,
        OpcBranch = 5'b11000,
        OpcJalr   = 5'b11001,
        OpcJal    = 5'b11011,
        OpcSystem = 5'b11100
    } opcode_e;

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        AluAdd  = 5'b00000,
        AluSub  = 5'b00001,
        AluSll  = 5'b00010,
        AluSlt  = 5'b00011,
        AluSltu = 5'b00100,
        AluXor  = 5'b00101,
        AluSra  = 5'b00110,
        AluSrl  = 5'b00111,
        AluOr   = 5'b01000,
        AluAnd  = 5'b01001,
        AluMul  = 5'b10000,
        AluRemu = 5'b10111
    } alu_op_e;

    typedef enum logic [2:0] {
        ImmU    = 3'b000,
        ImmI    = 3'b001,
        ImmS    = 3'b010,
        ImmB    = 3'b011,
        ImmJ    = 3'b100,
        ImmNone = 3'b111
    } imm_sel_e;

    // alt selects sub (funct3 0) or arithmetic shift (funct3 5).
    function automatic logic [ALU_OP_WIDTH-1:0] alu_from_funct3(input logic [2:0] funct3,
                                                                input logic       alt);
        logic [ALU_OP_WIDTH-1:0] op;
        case (funct3)
            3'd0:    op = alt ? AluSub : AluAdd;
            3'd1:    op = AluSll;
            3'd2:    op = AluSlt;
            3'd3:    op = AluSltu;
            3'd4:    op = AluXor;
            3'd5:    op = alt ? AluSra : AluSrl;
            3'd6:    op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

    // 32-bit immediate; the caller sign-extends to XLEN.
    function automatic logic [31:0] build_immediate(input logic [2:0]  sel,
                                                    input logic [31:0] instr);
        logic [31:0] imm;
        case (sel)
            ImmU:    imm = {instr[31:12], 12'b0};
            ImmI:    imm = {{20{instr[31]}}, instr[31:20]};
            ImmS:    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            ImmB:    imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            ImmJ:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm = 32'b0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/instruction_buffer_fifo.sv
// Instruction buffer between fetch and decode: BUFFER_DEPTH entries of {pc, instruction}.
// Ports:
//   clock, reset_n          : clock, asynchronous active-low reset
//   flush                   : empties the buffer, drops a same-cycle push
//   push, push_pc/instr     : write side
//   pop                     : consume the head entry
//   full, empty             : occupancy flags
//   head_pc/head_instruction: oldest entry (stale when empty)
module instruction_buffer_fifo
    import decode_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned BUFFER_DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [XLEN-1:0]        push_pc,
    input  logic [INSTR_WIDTH-1:0] push_instruction,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [XLEN-1:0]        head_pc,
    output logic [INSTR_WIDTH-1:0] head_instruction
);

    localparam int unsigned INDEX_WIDTH = $clog2(BUFFER_DEPTH);
    localparam int unsigned PTR_WIDTH   = INDEX_WIDTH + 1;

    // Extra MSB distinguishes full from empty when the index bits match.
    logic [PTR_WIDTH-1:0]   wr_ptr_q, rd_ptr_q;
    logic [INDEX_WIDTH-1:0] wr_index, rd_index;
    logic [XLEN-1:0]        pc_q    [BUFFER_DEPTH];
    logic [INSTR_WIDTH-1:0] instr_q [BUFFER_DEPTH];
    logic                   push_ok, pop_ok;

    assign wr_index = wr_ptr_q[INDEX_WIDTH-1:0];
    assign rd_index = rd_ptr_q[INDEX_WIDTH-1:0];
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PTR_WIDTH-1] != rd_ptr_q[PTR_WIDTH-1]) && (wr_index == rd_index);

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign head_pc          = pc_q[rd_index];
    assign head_instruction = instr_q[rd_index];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < BUFFER_DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) begin
                pc_q[wr_index]    <= push_pc;
                instr_q[wr_index] <= push_instruction;
                wr_ptr_q          <= wr_ptr_q + PTR_WIDTH'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/instruction_decode_stage.sv
// RV32I decode stage: instruction buffer, combinational decode of the buffer head,
// registered decode output with valid/ready toward execute, load-use interlock, flush.
// Optional macro DECODE_M_EXTENSION_EN makes OP with funct7=0000001 (mul..remu) legal.
// Ports:
//   clock, reset_n, flush                : clock, async active-low reset, pipeline flush
//   fetch_valid/ready/instruction/pc     : fetch side handshake and payload
//   execute_ready, decode_valid          : execute side handshake
//   decode_pc, decode_illegal            : pc and illegal flag of the held instruction
//   register_*                           : rd write enable/address, rs1/rs2 addresses
//   alu_*, immediate_select, immediate   : ALU control and immediate
//   data_memory_write(_back)_enable      : store / load
module instruction_decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BUFFER_DEPTH   = 2,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic                      fetch_valid,
    output logic                      fetch_ready,
    input  logic [31:0]               fetch_instruction,
    input  logic [XLEN-1:0]           fetch_pc,
    input  logic                      execute_ready,
    output logic                      decode_valid,
    output logic [XLEN-1:0]           decode_pc,
    output logic                      decode_illegal,
    output logic                      register_write_enable,
    output logic [REG_ADDR_WIDTH-1:0] register_write_address,
    output logic [REG_ADDR_WIDTH-1:0] register_read_address_a,
    output logic [REG_ADDR_WIDTH-1:0] register_read_address_b,
    output logic                      alu_immediate_enable,
    output logic [ALU_OP_WIDTH-1:0]   alu_operation,
    output logic [2:0]                immediate_select,
    output logic [XLEN-1:0]           immediate,
    output logic                      data_memory_write_enable,
    output logic                      data_memory_write_back_enable
);

    logic                   buf_full, buf_empty, push, advance, hazard;
    logic [XLEN-1:0]        head_pc;
    logic [INSTR_WIDTH-1:0] head_instr;

    assign fetch_ready = !buf_full;
    assign push        = fetch_valid && fetch_ready && !flush;

    instruction_buffer_fifo #(
        .XLEN         (XLEN),
        .BUFFER_DEPTH (BUFFER_DEPTH)
    ) u_buffer (
        .clock            (clock),
        .reset_n          (reset_n),
        .flush            (flush),
        .push             (push),
        .push_pc          (fetch_pc),
        .push_instruction (fetch_instruction),
        .pop              (advance),
        .full             (buf_full),
        .empty            (buf_empty),
        .head_pc          (head_pc),
        .head_instruction (head_instr)
    );

    logic [4:0]                opcode;
    logic [2:0]                funct3;
    logic [6:0]                funct7;
    logic [REG_ADDR_WIDTH-1:0] rd, rs1, rs2;

    assign opcode = head_instr[6:2];
    assign funct3 = head_instr[14:12];
    assign funct7 = head_instr[31:25];
    assign rd     = REG_ADDR_WIDTH'(head_instr[11:7]);
    assign rs1    = REG_ADDR_WIDTH'(head_instr[19:15]);
    assign rs2    = REG_ADDR_WIDTH'(head_instr[24:20]);

    logic                    illegal_d, write_enable_d, imm_enable_d, mem_write_d, mem_load_d;
    logic                    uses_rs1, uses_rs2;
    logic [ALU_OP_WIDTH-1:0] alu_op_d;
    logic [2:0]              imm_sel_d;
    logic [XLEN-1:0]         immediate_d;

    always_comb begin
        illegal_d      = (head_instr[1:0] != 2'b11);
        write_enable_d = 1'b0;
        imm_enable_d   = 1'b0;
        mem_write_d    = 1'b0;
        mem_load_d     = 1'b0;
        uses_rs1       = 1'b1;
        uses_rs2       = 1'b0;
        alu_op_d       = AluAdd;
        imm_sel_d      = ImmNone;
        case (opcode)
            OpcOp: begin
                write_enable_d = 1'b1;
                uses_rs2       = 1'b1;
                case (funct7)
                    7'b0000000: alu_op_d = alu_from_funct3(funct3, 1'b0);
                    7'b0100000: begin
                        alu_op_d = alu_from_funct3(funct3, 1'b1);
                        if (funct3 != 3'd0 && funct3 != 3'd5) illegal_d = 1'b1;
                    end
`ifdef DECODE_M_EXTENSION_EN
                    7'b0000001: alu_op_d = {2'b10, funct3};
`endif
                    default:    illegal_d = 1'b1;
                endcase
            end
            OpcOpImm: begin
                write_enable_d = 1'b1;
                imm_enable_d   = 1'b1;
                imm_sel_d      = ImmI;
                alu_op_d       = alu_from_funct3(funct3, (funct3 == 3'd5) && funct7[5]);
                // Shift-immediates reuse funct7; only srai may set bit 30.
                if ((funct3 == 3'd1 && funct7 != 7'b0000000) ||
                    (funct3 == 3'd5 && funct7 != 7'b0000000 && funct7 != 7'b0100000)) begin
                    illegal_d = 1'b1;
                end
            end
            OpcBranch: begin
                imm_sel_d = ImmB;
                uses_rs2  = 1'b1;
                if (funct3 == 3'd2 || funct3 == 3'd3) illegal_d = 1'b1;
            end
            OpcJal: begin
                write_enable_d = 1'b1;
                imm_enable_d   = 1'b1;
                imm_sel_d      = ImmJ;
                uses_rs1       = 1'b0;
            end
            OpcJalr: begin
                write_enable_d = 1'b1;
                imm_enable_d   = 1'b1;
                imm_sel_d      = ImmI;
                if (funct3 != 3'd0) illegal_d = 1'b1;
            end
            OpcAuipc, OpcLui: begin
                write_enable_d = 1'b1;
                imm_enable_d   = 1'b1;
                imm_sel_d      = ImmU;
                uses_rs1       = 1'b0;
            end
            OpcLoad: begin
                write_enable_d = 1'b1;
                imm_enable_d   = 1'b1;
                imm_sel_d      = ImmI;
                mem_load_d     = 1'b1;
                if (funct3 == 3'd3 || funct3 >= 3'd6) illegal_d = 1'b1;
            end
            OpcStore: begin
                imm_enable_d = 1'b1;
                imm_sel_d    = ImmS;
                mem_write_d  = 1'b1;
                uses_rs2     = 1'b1;
                if (funct3 > 3'd2) illegal_d = 1'b1;
            end
            OpcSystem: begin
                imm_enable_d = 1'b1;
                imm_sel_d    = ImmI;
            end
            default: illegal_d = 1'b1;
        endcase
        if (rd == '0) write_enable_d = 1'b0;
        // An illegal instruction must have no architectural side effects.
        if (illegal_d) begin
            write_enable_d = 1'b0;
            imm_enable_d   = 1'b0;
            mem_write_d    = 1'b0;
            mem_load_d     = 1'b0;
            uses_rs1       = 1'b0;
            uses_rs2       = 1'b0;
            alu_op_d       = AluAdd;
            imm_sel_d      = ImmNone;
        end
    end

    assign immediate_d = XLEN'($signed(build_immediate(imm_sel_d, head_instr)));

    logic                      valid_q, illegal_q, write_enable_q, imm_enable_q;
    logic                      mem_write_q, mem_load_q;
    logic [XLEN-1:0]           pc_q, immediate_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rs1_q, rs2_q;
    logic [ALU_OP_WIDTH-1:0]   alu_op_q;
    logic [2:0]                imm_sel_q;

    // A load still in the output register cannot forward to the head yet.
    assign hazard = valid_q && mem_load_q && (rd_q != '0) &&
                    ((uses_rs1 && rs1 == rd_q) || (uses_rs2 && rs2 == rd_q));

    assign advance = (!valid_q || execute_ready) && !buf_empty && !hazard && !flush;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q        <= 1'b0;
            pc_q           <= '0;
            illegal_q      <= 1'b0;
            write_enable_q <= 1'b0;
            rd_q           <= '0;
            rs1_q          <= '0;
            rs2_q          <= '0;
            imm_enable_q   <= 1'b0;
            alu_op_q       <= '0;
            imm_sel_q      <= '0;
            immediate_q    <= '0;
            mem_write_q    <= 1'b0;
            mem_load_q     <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (advance) begin
            valid_q        <= 1'b1;
            pc_q           <= head_pc;
            illegal_q      <= illegal_d;
            write_enable_q <= write_enable_d;
            rd_q           <= rd;
            rs1_q          <= rs1;
            rs2_q          <= rs2;
            imm_enable_q   <= imm_enable_d;
            alu_op_q       <= alu_op_d;
            imm_sel_q      <= imm_sel_d;
            immediate_q    <= immediate_d;
            mem_write_q    <= mem_write_d;
            mem_load_q     <= mem_load_d;
        end else if (execute_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign decode_valid                  = valid_q;
    assign decode_pc                     = pc_q;
    assign decode_illegal                = illegal_q;
    assign register_write_enable         = write_enable_q;
    assign register_write_address        = rd_q;
    assign register_read_address_a       = rs1_q;
    assign register_read_address_b       = rs2_q;
    assign alu_immediate_enable          = imm_enable_q;
    assign alu_operation                 = alu_op_q;
    assign immediate_select              = imm_sel_q;
    assign immediate                     = immediate_q;
    assign data_memory_write_enable      = mem_write_q;
    assign data_memory_write_back_enable = mem_load_q;

endmodule

// File: doc/instruction_decode_stage.md
Name: instruction_decode_stage

Overview:
Pipelined RV32I decode stage between fetch and execute. An instruction buffer absorbs fetch/execute rate mismatch. A registered decode output drives execute through a valid/ready handshake. The block adds load-use interlock, flush, illegal-instruction detection and immediate generation, and gives full write-enable coverage for JALR and LUI.

Parameters:
- XLEN, 32, datapath width of pc and immediate.
- BUFFER_DEPTH, 2, instruction buffer entries; power of two, >=2.
- REG_ADDR_WIDTH, 5, register address width.

Ports:
- clock  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush (taken branch/jump).
- fetch_valid  in  1  fetch offers instruction.
- fetch_ready  out  1  buffer not full.
- fetch_instruction  in  32  raw instruction.
- fetch_pc  in  XLEN  instruction address.
- execute_ready  in  1  execute accepts decode output.
- decode_valid  out  1  decode output holds an instruction.
- decode_pc  out  XLEN  pc of decoded instruction.
- decode_illegal  out  1  unsupported or malformed encoding.
- register_write_enable  out  1  rd written.
- register_write_address  out  REG_ADDR_WIDTH  rd.
- register_read_address_a  out  REG_ADDR_WIDTH  rs1.
- register_read_address_b  out  REG_ADDR_WIDTH  rs2.
- alu_immediate_enable  out  1  ALU operand B is immediate.
- alu_operation  out  5  ALU op code.
- immediate_select  out  3  immediate format.
- immediate  out  XLEN  sign-extended immediate.
- data_memory_write_enable  out  1  store.
- data_memory_write_back_enable  out  1  load.

Behaviour:
- Reset: every decode output is 0, decode_valid is 0, the buffer is empty, and fetch_ready is 1.
- Fetch handshake: an instruction is pushed when fetch_valid && fetch_ready. fetch_ready = !full.
- Advance condition: the output register loads the buffer head when (!decode_valid || execute_ready) && !empty && !hazard && !flush.
- Latency: an instruction pushed into an empty buffer at edge t appears with decode_valid=1 after edge t+1. Sustained throughput is 1 instruction per cycle.
- Drain: if the advance condition is false but execute_ready=1, decode_valid drops to 0 (bubble).
- Hold: while decode_valid && !execute_ready, all decode outputs are held stable.
- Simultaneous push and pop on a full buffer is allowed. fetch_ready is computed from the current occupancy only, so it stays 0 that cycle.
- Buffer pointers have log2(BUFFER_DEPTH)+1 bits and wrap modulo 2*BUFFER_DEPTH. full and empty are derived from the MSB and the index bits.
- Hazard: hazard=1 when all of the following hold:
  - decode_valid=1 and the output register holds a load with rd!=0;
  - the head uses rs1 (all formats except U and J) with rs1==rd, or uses rs2 (R, S, B) with rs2==rd.
  - Result: exactly one bubble is inserted after the load.
- Flush has top priority and takes effect at the next edge:
  - buffer emptied, decode_valid set to 0;
  - any fetch push in the same cycle is dropped.
- Opcode decode on instruction[6:2] requires instruction[1:0]==2'b11; anything else is illegal:
  - 01100 OP, 00100 OP-IMM, 11000 BRANCH, 11011 JAL, 11001 JALR, 00101 AUIPC, 01101 LUI, 00000 LOAD, 01000 STORE, 11100 SYSTEM.
  - Any other opcode is illegal.
- Illegal instructions force register_write_enable and both memory enables to 0.
- register_write_enable: set for OP, OP-IMM, JAL, JALR, AUIPC, LUI, LOAD; forced to 0 when rd==0.
- alu_operation codes:
  - add 00000, sub 00001 (OP with funct7[5]).
  - sll 00010, slt 00011, sltu 00100, xor 00101.
  - sra 00110 / srl 00111 (selected by funct7[5]).
  - or 01000, and 01001.
  - Non-ALU opcodes output add.
- immediate_select: U 000, I 001, S 010, B 011, J 100, none 111. The immediate is sign-extended to XLEN; B and J have bit0=0.
- Reset asserted mid-operation clears everything asynchronously. In-flight instructions are lost.

Optional Feature:
- Macro: DECODE_M_EXTENSION_EN.
- Defined: OP with funct7==0000001 decodes as legal, with alu_operation 10000 + funct3 (mul..remu).
- Undefined: that encoding sets decode_illegal=1 with register_write_enable=0.

Decomposition:
- Package decode_pkg holds:
  - opcode constants;
  - alu_operation codes (including M codes);
  - immediate_select codes;
  - the ALU_OP_WIDTH=5 constant.
- One sub-module, instruction_buffer_fifo (BUFFER_DEPTH x {XLEN pc, 32 instruction}), with push/pop/flush and full/empty outputs. Decode logic and hazard logic stay in the top.

Test Plan:
- Reset: reset_n=0 mid-stream -> all outputs 0, fetch_ready=1, decode_valid=0 immediately (asynchronous).
- Basic decode: push 0x00500093 (ADDI x1,x0,5) at pc 0x0 -> after two edges:
  - decode_valid=1, rd=1, rs1=0;
  - alu_operation=00000, immediate_select=001, immediate=0x5;
  - alu_immediate_enable=1, register_write_enable=1.
- Load-use: push 0x0000A103 (LW x2,0(x1)) then 0x002101B3 (ADD x3,x2,x2), execute_ready=1 -> LW, one bubble cycle, then ADD. Repeat with ADD x3,x1,x1 -> no bubble.
- Backpressure: execute_ready=0, push BUFFER_DEPTH+1 instructions -> fetch_ready=0 once full, decode outputs stable. Release -> in-order drain at one per cycle.
- Flush: full buffer, fetch_valid=1 and flush=1 in the same cycle -> next cycle decode_valid=0, empty buffer, fetch_ready=1, pushed instruction never appears.
- M extension: push 0x027302B3 (MUL x5,x6,x7):
  - with DECODE_M_EXTENSION_EN -> alu_operation=10000, decode_illegal=0;
  - without -> decode_illegal=1, register_write_enable=0.
